adder_rr_scheduler: RTL

Round-robin scheduler that shares one registered 5-bit prefix adder (two-edge latency: input DFF stage, output DFF stage, no reset on its flops) among `NUM_REQ` requesters. It grants at most one operand pair per cycle with a valid/ready handshake and tracks each issued operation through a two-stage tag pipeline. It returns the adder's sum/carry to the originating requester as a one-cycle response pulse. It sits between the requester ports and the adder instance, and also provides an enable/drain control for quiescing the adder.

---
 rtl/adder_rr_scheduler_if.sv | 29 ++
 rtl/adder_rr_scheduler.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler_if.sv
// rtl/adder_rr_scheduler_if.sv - requester/response and adder-side bus for adder_rr_scheduler
interface adder_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 5
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W-1:0]         resp_sum;
  logic                 resp_cout;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic [W-1:0]         add_sum;
  logic                 add_cout;

  // Requesters plus the adder instance
  modport master (
    output req_valid, req_a, req_b, add_sum, add_cout,
    input  req_ready, resp_valid, resp_sum, resp_cout, add_a, add_b
  );

  // The scheduler
  modport slave (
    input  req_valid, req_a, req_b, add_sum, add_cout,
    output req_ready, resp_valid, resp_sum, resp_cout, add_a, add_b
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin sharing of one registered adder; optional counters via ADDER_SCHED_STATS_EN
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  adder_rr_scheduler_if.slave  bus,
  output logic                 idle
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_ovf
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic               s1_valid;
  logic [PW-1:0]      s1_id;
  logic               s2_valid;
  logic [PW-1:0]      s2_id;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      grant_id;
  logic               xfer;

  // (base + k) mod NUM_REQ, with k < NUM_REQ
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PW-1:0];
  endfunction

  // Round-robin search upward from ptr; grants only while in RUN
  always_comb begin
    grant    = '0;
    grant_id = '0;
    xfer     = 1'b0;
    if (state == S_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!xfer && bus.req_valid[wrap_add(ptr, k)]) begin
          xfer                     = 1'b1;
          grant_id                 = wrap_add(ptr, k);
          grant[wrap_add(ptr, k)]  = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // Granted operands to the adder; zero when idle so its input flops settle to a known value
  always_comb begin
    bus.add_a = '0;
    bus.add_b = '0;
    if (xfer) begin
      bus.add_a = bus.req_a[int'(grant_id)*W +: W];
      bus.add_b = bus.req_b[int'(grant_id)*W +: W];
    end
  end

  // Control FSM; idle is registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_RUN;
            idle  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Nothing issues in DRAIN, so an empty stage1 means both stages are empty after this edge
          if (!s1_valid) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  // Rotate pointer past each granted requester; follow each issued op through the two adder stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
    end else begin
      if (xfer) ptr <= wrap_add(grant_id, 1);
      s1_valid <= xfer;
      s1_id    <= grant_id;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  // Route the adder result back to the requester that issued it
  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid[i] = s2_valid && (s2_id == PW'(i));
    end
  end

  assign bus.resp_sum  = bus.add_sum;
  assign bus.resp_cout = bus.add_cout;

`ifdef ADDER_SCHED_STATS_EN
  // Saturating counts of responses and of responses with carry out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (s2_valid) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (bus.add_cout && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif
endmodule
